// File: rtl/smvm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : smvm_pkg
// Description : Shared widths, state encodings and result FIFO entry layout.
// Revision    : 1.0 - initial release
// ============================================================================
package smvm_pkg;

    localparam int SMVM_DATA_W  = 12;
    localparam int SMVM_ROW_W   = 9;
    localparam int SMVM_ENTRY_W = SMVM_ROW_W + 1 + SMVM_DATA_W;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = c_ST_IDLE,
        S_RUN   = c_ST_RUN,
        S_DRAIN = c_ST_DRAIN
    } state_t;

    // FIFO entry layout, MSB first: {row, last, data}
    typedef struct packed {
        logic [SMVM_ROW_W-1:0]  row;
        logic                   last;
        logic [SMVM_DATA_W-1:0] data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/smvm_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module      : smvm_result_collector_if
// Description : Config, result-in and result-out handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface smvm_result_collector_if #(
    parameter int DATA_W = 12,
    parameter int ROW_W  = 9
) ();

    logic              cfg_valid;
    logic [ROW_W-1:0]  cfg_rows;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output cfg_valid, cfg_rows, in_valid, in_data, out_ready,
        input  out_valid, out_data, out_row, out_last, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_rows, in_valid, in_data, out_ready,
        output out_valid, out_data, out_row, out_last, busy, done, err
    );

endinterface
`default_nettype wire

// File: rtl/smvm_result_collector_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Generic first-word-fall-through FIFO; head shown on dout.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       push,
    input  wire logic                       pop,
    input  wire logic [WIDTH-1:0]           din,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_FULL    = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL);
    assign count     = r_count;
    assign w_do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the full-FIFO push lands in
    assign w_do_push = push & (~full | w_do_pop);
    // Empty head reads as zero so idle outputs are clean
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/smvm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : smvm_result_collector
// Description : Buffers the SMVM result stream, tags rows, flags job end/errors.
// Revision    : 1.0 - initial release
// ============================================================================
module smvm_result_collector
    import smvm_pkg::*;
#(
    parameter int DATA_W = SMVM_DATA_W,
    parameter int ROW_W  = SMVM_ROW_W,
    parameter int DEPTH  = 16
) (
    input  wire logic                clk,
    input  wire logic                rst,
    smvm_result_collector_if.slave   bus
);

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int ENTRY_W = ROW_W + 1 + DATA_W;
    localparam logic [ROW_W-1:0] c_ROW_ONE = {{(ROW_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]  c_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_next;
    logic [ROW_W-1:0]   r_rows;
    logic [ROW_W-1:0]   r_wr_row;
    logic               r_err;
    logic               r_done;
    logic               r_last_lost;

    logic               w_cfg_accept;
    logic               w_cfg_nonzero;
    logic               w_done_next;
    logic               w_in_run;
    logic               w_tag_last;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_drain_exit;
    logic               w_head_last;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;
    logic               w_full;
    logic               w_empty;
    logic [ADDR_W:0]    w_count;

    assign w_cfg_nonzero = (bus.cfg_rows != '0);
    assign w_in_run      = bus.in_valid & (r_state == S_RUN);
    assign w_tag_last    = (r_wr_row == (r_rows - c_ROW_ONE));
    assign w_pop         = ~w_empty & bus.out_ready;
    assign w_push        = w_in_run & (~w_full | w_pop);
    assign w_drop        = bus.in_valid & ~w_push;
    assign w_din         = {r_wr_row, w_tag_last, bus.in_data};
    assign w_head_last   = w_dout[DATA_W];

    // A lost final word means no last=1 entry will ever pop; leave once drained
    assign w_drain_exit  = (w_pop & w_head_last)
                         | (r_last_lost & ((w_pop & (w_count == c_CNT_ONE)) | w_empty));

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_state_next = r_state;
        w_cfg_accept = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cfg_valid) begin
                    w_cfg_accept = 1'b1;
                    if (w_cfg_nonzero) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.in_valid && w_tag_last) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_exit) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rows      <= '0;
            r_wr_row    <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_last_lost <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
            r_err   <= (r_err & ~w_cfg_accept) | w_drop;
            if (w_cfg_accept && w_cfg_nonzero) begin
                r_rows      <= bus.cfg_rows;
                r_wr_row    <= '0;
                r_last_lost <= 1'b0;
            end else if (w_in_run) begin
                // Dropped words still advance the tag to stay aligned with SMVM rows
                r_wr_row <= r_wr_row + c_ROW_ONE;
                if (w_drop && w_tag_last) begin
                    r_last_lost <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = ~w_empty;
    assign bus.out_data  = w_dout[DATA_W-1:0];
    assign bus.out_last  = w_dout[DATA_W];
    assign bus.out_row   = w_dout[ENTRY_W-1 -: ROW_W];
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_smvm_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_smvm_result_collector
// Description : Directed and random jobs against a queue-based result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smvm_result_collector;

    localparam int DEPTH = 16;

    typedef struct {
        logic [8:0]  row;
        logic        last;
        logic [11:0] data;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    ent_t q[$];
    bit   m_busy;
    bit   m_done;
    bit   m_err;
    int   m_rows;
    int   m_rem;

    smvm_result_collector_if #(.DATA_W(12), .ROW_W(9)) bus ();

    smvm_result_collector #(
        .DATA_W (12),
        .ROW_W  (9),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string ctx);
        check({ctx, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({ctx, ".out_data"}, 32'(bus.out_data), 32'(q[0].data));
            check({ctx, ".out_row"},  32'(bus.out_row),  32'(q[0].row));
            check({ctx, ".out_last"}, 32'(bus.out_last), 32'(q[0].last));
        end
        check({ctx, ".busy"}, 32'(bus.busy), 32'(m_busy));
        check({ctx, ".done"}, 32'(bus.done), 32'(m_done));
        check({ctx, ".err"},  32'(bus.err),  32'(m_err));
    endtask

    // One clock cycle: drive, compare against the model, advance model and clock
    task automatic step(input string ctx, input bit cv, input int cr, input bit iv,
                        input int id, input bit rdy);
        bit   pop;
        bit   accept;
        bit   drop;
        bit   busy0;
        int   rem0;
        ent_t e;
        ent_t gone;
        bus.cfg_valid = cv;
        bus.cfg_rows  = 9'(cr);
        bus.in_valid  = iv;
        bus.in_data   = 12'(id);
        bus.out_ready = rdy;
        #1;
        check_outputs(ctx);
        pop    = (q.size() != 0) && rdy;
        accept = 1'b0;
        drop   = 1'b0;
        busy0  = m_busy;
        rem0   = m_rem;
        if (iv) begin
            if (rem0 > 0) begin
                e.row  = 9'(m_rows - rem0);
                e.last = (rem0 == 1);
                e.data = 12'(id);
                if (q.size() < DEPTH || pop) accept = 1'b1;
                else drop = 1'b1;
                m_rem--;
            end else begin
                drop = 1'b1;
            end
        end
        if (pop) gone = q.pop_front();
        if (accept) q.push_back(e);
        m_done = 1'b0;
        if (!busy0 && cv) begin
            m_err = 1'b0;
            if (cr == 0) m_done = 1'b1;
            else begin
                m_busy = 1'b1;
                m_rows = cr;
                m_rem  = cr;
            end
        end
        if (drop) m_err = 1'b1;
        if (busy0 && rem0 == 0 && pop && q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string ctx);
        int cyc = 0;
        while (m_busy && cyc < 200) begin
            step(ctx, 0, 0, 0, 0, 1);
            cyc++;
        end
        step({ctx, ".after"}, 0, 0, 0, 0, 1);
        check({ctx, ".ended"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic model_clear();
        q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_rows = 0;
        m_rem  = 0;
    endtask

    initial begin
        int fed;
        int cyc;
        int rows;
        bit iv;
        n_checks = 0;
        n_pass   = 0;
        model_clear();
        rst = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_rows  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.out_data", 32'(bus.out_data), 32'd0);
        check("rst.out_row",  32'(bus.out_row),  32'd0);
        check("rst.out_last", 32'(bus.out_last), 32'd0);
        check_outputs("rst");
        rst = 1'b0;

        // Basic three-row job
        step("basic.cfg", 1, 3, 0, 0, 1);
        step("basic.w0", 0, 0, 1, 12'h00A, 1);
        step("basic.w1", 0, 0, 1, 12'h00B, 1);
        step("basic.w2", 0, 0, 1, 12'h00C, 1);
        drain("basic");

        // Backpressure: eight words, ten stalled cycles
        step("bp.cfg", 1, 8, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("bp.w", 0, 0, 1, 12'h100 + i, 0);
        step("bp.stall", 0, 0, 0, 0, 0);
        step("bp.stall", 0, 0, 0, 0, 0);
        drain("bp");

        // Overflow: rows 16..19 dropped, including the last one
        step("ovf.cfg", 1, 20, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("ovf.w", 0, 0, 1, 12'h200 + i, 0);
        check("ovf.err", 32'(bus.err), 32'd1);
        drain("ovf");

        // Full FIFO with push and pop in the same cycle
        step("fp.cfg", 1, 17, 0, 0, 0);
        for (int i = 0; i < 16; i++) step("fp.w", 0, 0, 1, 12'h300 + i, 0);
        step("fp.pushpop", 0, 0, 1, 12'h3FF, 1);
        check("fp.err", 32'(bus.err), 32'd0);
        drain("fp");

        // Zero-row job, stray word in IDLE, cfg ignored during RUN
        step("zero.cfg", 1, 0, 0, 0, 1);
        step("zero.done", 0, 0, 0, 0, 1);
        step("stray", 0, 0, 1, 12'h0EE, 1);
        step("stray.err", 0, 0, 0, 0, 1);
        step("proto.cfg", 1, 2, 0, 0, 1);
        step("proto.w0", 1, 5, 1, 12'h0A1, 1);
        step("proto.w1", 0, 0, 1, 12'h0A2, 1);
        drain("proto");

        // Reset with five entries buffered
        step("mid.cfg", 1, 10, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("mid.w", 0, 0, 1, 12'h400 + i, 0);
        rst = 1'b1;
        #1;
        model_clear();
        check_outputs("mid.rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("mid.post", 0, 0, 0, 0, 1);
        step("mid2.cfg", 1, 2, 0, 0, 1);
        step("mid2.w0", 0, 0, 1, 12'h555, 1);
        step("mid2.w1", 0, 0, 1, 12'h666, 1);
        drain("mid2");

        // Random jobs with bursty input and random consumer stalls
        for (int j = 0; j < 8; j++) begin
            rows = $urandom_range(1, 40);
            fed  = 0;
            cyc  = 0;
            step("rnd.cfg", 1, rows, 0, 0, $urandom_range(0, 1) == 1);
            while (m_busy && cyc < 1000) begin
                iv = (fed < rows) && ($urandom_range(0, 3) != 0);
                step("rnd", 0, 0, iv, int'($urandom & 32'hFFF), $urandom_range(0, 3) != 0);
                if (iv) fed++;
                cyc++;
            end
            drain("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/smvm_result_collector.md
# smvm_result_collector

Output stage directly downstream of the SMVM core. It captures the core's non-stallable 12-bit result stream (one word per matrix row, arriving in bursts) into a small FIFO and tags each word with its row index. It presents the results to the consumer over a valid/ready handshake with an end-of-job marker. It also reports job completion and sticky overflow/protocol errors.

## Interface
- `DATA_W`, 12, result word width (matches SMVM `data_out`)
- `ROW_W`, 9, row-count/row-index width (matches SMVM row field)
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_valid` in 1: job start strobe; sampled only in IDLE.
- `cfg_rows` in ROW_W: number of result words expected for the job.
- `in_valid` in 1: result word present. Driven by SMVM `out_valid`; no backpressure is possible.
- `in_data` in DATA_W: result word. Driven by SMVM `data_out`.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts the head.
- `out_data` out DATA_W: head result word.
- `out_row` out ROW_W: row index of the head word, 0-based.
- `out_last` out 1: head is the final row of the job.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at job completion.
- `err` out 1: sticky error flag; cleared on cfg accept.

## Operation
- States: IDLE, RUN, DRAIN. Reset puts the block in IDLE.
- IDLE
  - `cfg_valid` with `cfg_rows` ≠ 0: latch `rows`, set `wr_row` = 0, clear `err`, go to RUN.
  - `cfg_valid` with `cfg_rows` = 0: clear `err`, pulse `done` next cycle, stay in IDLE.
- RUN
  - Each `in_valid` pushes {`wr_row`, last = (`wr_row` == `rows`−1), `in_data`} and increments `wr_row`.
  - The push with last = 1 moves the block to DRAIN.
- DRAIN
  - Return to IDLE on the handshake that pops the last = 1 entry.
  - Pulse `done` the cycle after that handshake.
- A pop occurs when `out_valid` && `out_ready`. The FIFO is first-word-fall-through: `out_*` show the head entry directly.
- Full and push without pop: the word is dropped and `err` is set. `wr_row` still increments, so later tags stay aligned with the SMVM row order.
- Full and push with pop in the same cycle: the push is accepted and occupancy stays at DEPTH.
- `in_valid` in IDLE or DRAIN: the word is dropped and `err` is set.
- `cfg_valid` in RUN or DRAIN: ignored; no error.
- Pointer wrap: read/write pointers are ADDR_W = log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is ADDR_W+1 bits.
- If the last = 1 word itself is dropped because the FIFO is full:
  - The block enters a stuck DRAIN.
  - It exits DRAIN when the FIFO goes empty, pulses `done`, and `err` remains set.

## Timing
- Reset values: `out_valid` = 0, `out_data` = 0, `out_row` = 0, `out_last` = 0, `busy` = 0, `done` = 0, `err` = 0; FIFO empty; pointers = 0.
- Push-to-output latency is 1 cycle: a word written at edge N is visible on `out_*` after edge N. There is no combinational bypass from `in_*` to `out_*`.
- While `out_valid` && !`out_ready`, `out_data`, `out_row` and `out_last` are held stable.
- `out_ready` may toggle freely. `out_valid` never depends combinationally on `out_ready`.
- Sustained throughput: 1 push and 1 pop per cycle.
- `busy` rises the cycle after cfg accept. It falls in the same cycle `done` is asserted.
- Reset asserted mid-job clears all state immediately. Entries in flight are discarded and no `done` pulse is issued.

## Structure
- Shared package `smvm_pkg`:
  - constants `SMVM_DATA_W` = 12 and `SMVM_ROW_W` = 9;
  - state encodings IDLE/RUN/DRAIN as localparams;
  - the FIFO entry layout {row, last, data}, width ROW_W+1+DATA_W.
- Sub-module `sync_fifo`: generic FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - The collector owns only the FSM, row tagging and error logic.

## Test plan
- Basic job: `cfg_rows` = 3, then 3 back-to-back `in_valid` words 0x00A, 0x00B, 0x00C with `out_ready` = 1.
  - Outputs (row, data, last) in order: (0, 0x00A, 0), (1, 0x00B, 0), (2, 0x00C, 1).
  - `done` pulses once. `err` = 0.
- Backpressure: `cfg_rows` = 8, burst of 8 words, `out_ready` held 0 for 10 cycles then set to 1.
  - All 8 words are delivered in order with stable outputs while stalled.
  - `done` pulses after the 8th pop.
- Overflow: `DEPTH` = 16, `cfg_rows` = 20, 20 consecutive words, `out_ready` = 0.
  - Words 16–19 are dropped and `err` = 1.
  - The FIFO delivers rows 0–15; row 15 has `out_last` = 0.
  - After draining, the block exits stuck DRAIN and pulses `done`.
- Full with simultaneous pop: FIFO full, then a push and pop in the same cycle.
  - Occupancy stays at 16 and the new word appears later in the correct order.
- Protocol corner cases:
  - `cfg_rows` = 0 gives a `done` pulse with `busy` staying 0.
  - `in_valid` in IDLE sets `err`, which the next cfg accept clears.
  - `cfg_valid` during RUN is ignored.
- Reset mid-job: `rst` asserted with 5 entries buffered.
  - Next cycle: `out_valid` = 0, `busy` = 0, `err` = 0, no `done` pulse.
  - A new `cfg_rows` = 2 job then completes normally.
